shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Command-driven controller for the team's 8-bit rotate/shift register. It sequences the register through a parallel load, then N shift cycles, then captures the result.
- A requester issues one command: data, amount, direction and fill mode. The block drives the register's load, shift-enable, direction and zero-fill controls, and returns the shifted word with a done pulse.
- It sits between the user-facing control logic (switches/keys or an upstream FSM) and the shift register datapath.

Parameters:
- WIDTH, 8, data width of the controlled shift register.
- CNT_W, 3, width of the shift-amount field. Maximum amount is 2^CNT_W-1.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset_b  input  1  asynchronous, active-low reset.
- start  input  1  command request, sampled only in IDLE.
- cmd_data  input  WIDTH  value to parallel-load.
- cmd_amount  input  CNT_W  number of shift cycles.
- cmd_right  input  1  1 = shift/rotate right, 0 = rotate left.
- cmd_fill0  input  1  1 = logical right shift (zero into MSB), 0 = rotate. Ignored when cmd_right=0.
- sr_q  input  WIDTH  current shift register contents.
- sr_load  output  1  parallel-load strobe to register.
- sr_data  output  WIDTH  parallel-load value.
- sr_shift_en  output  1  register shifts this cycle. 0 = hold.
- sr_right  output  1  direction select to register.
- sr_fill0  output  1  zero-fill select to register.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  captured shifted word.
- result_valid  output  1  result holds output of last completed command.

Behaviour:
- Reset (Reset_b=0, asynchronous): state=IDLE; all outputs 0, including result, result_valid and sr_data; counter and command registers 0.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - busy=0.
  - If start=1: latch cmd_* into internal registers, clear result_valid, go to LOAD.
- LOAD (1 cycle):
  - sr_load=1, sr_data=latched data, sr_shift_en=0, busy=1.
  - Counter <= latched amount.
  - Next state: SHIFT if amount != 0, else DONE.
- SHIFT:
  - sr_shift_en=1, sr_right and sr_fill0 from the latched command, busy=1.
  - Counter decrements each cycle. Leave to DONE on the cycle where counter == 1, giving exactly amount shift cycles.
- DONE (1 cycle):
  - done=1, busy=1, sr_shift_en=0.
  - On the closing edge: result <= sr_q, result_valid <= 1, state <= IDLE.
- Latency: start sampled high at cycle 0 -> LOAD at cycle 1 -> SHIFT at cycles 2..1+N -> DONE at cycle 2+N -> result_valid from cycle 3+N.
- A new start may be accepted in the first IDLE cycle after DONE.
- sr_right and sr_fill0 are 0 outside SHIFT.
- sr_data holds the last loaded value between commands.
- start while busy=1 is ignored, not queued. The cmd_* inputs are don't-care outside the accept cycle.
- cmd_right=0 forces sr_fill0=0.
- The counter never underflows; amount=0 bypasses SHIFT.
- Reset mid-command aborts immediately; the register contents are not restored.
- Only one of sr_load or sr_shift_en is ever high in a cycle.

Optional Feature:
- Macro SHSEQ_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort=1 in LOAD or SHIFT: go to IDLE on the next edge. No done pulse, result_valid stays 0, result is unchanged, sr_shift_en drops the cycle after.
  - abort in IDLE or DONE has no effect.
- Undefined: no abort port; every accepted command runs to DONE.

Test Plan:
- Bench drives a behavioural 8-bit register from sr_*.
- Rotate right: start with data=0x81, amount=1, right=1, fill0=0 -> done at cycle 3, result=0xC0, busy high for cycles 1-3.
- Logical right: data=0xF0, amount=3, right=1, fill0=1 -> exactly 3 sr_shift_en cycles, result=0x1E, done at cycle 5.
- Rotate left with fill0 ignored: data=0x81, amount=1, right=0, fill0=1 -> sr_fill0 stays 0, result=0x03. Then data=0x01, amount=7, right=0 -> result=0x80.
- Zero amount: data=0x5A, amount=0 -> no sr_shift_en, done at cycle 2, result=0x5A.
- Start during busy: second start (data=0xFF) pulsed during SHIFT of a 0x81/amount=5 command -> ignored, single done, result=0x81 rotated right 5 = 0x0C.
- Asynchronous reset mid-SHIFT: Reset_b low between edges -> busy, done, result and result_valid are 0 immediately, state=IDLE. A new command after release completes normally.
- With SHSEQ_ABORT_EN: abort during SHIFT -> no done pulse, result_valid=0, back in IDLE the next cycle.

Source files
------------

// File: rtl/shift_sequencer.sv
// Command-driven controller for an external rotate/shift register: parallel load, N shifts, capture.
// Defining SHSEQ_ABORT_EN adds an abort input that cancels a command during LOAD or SHIFT.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             Clock,
    input  logic             Reset_b,
    input  logic             start,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_amount,
    input  logic             cmd_right,
    input  logic             cmd_fill0,
`ifdef SHSEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] sr_q,
    output logic             sr_load,
    output logic [WIDTH-1:0] sr_data,
    output logic             sr_shift_en,
    output logic             sr_right,
    output logic             sr_fill0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [1:0]       dbg_state
);

    // Handshake: start is accepted only while busy=0 (IDLE); starts seen while busy=1 are dropped.
    // Each accepted command yields exactly one done pulse, after which result/result_valid are updated.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat_amount;
    logic             lat_right;
    logic             lat_fill0;
    logic             abort_req;

`ifdef SHSEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign dbg_state = state;

    // All outputs are registered: each transition writes the output values of the state being entered.
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state        <= S_IDLE;
            cnt          <= '0;
            lat_amount   <= '0;
            lat_right    <= 1'b0;
            lat_fill0    <= 1'b0;
            sr_load      <= 1'b0;
            sr_data      <= '0;
            sr_shift_en  <= 1'b0;
            sr_right     <= 1'b0;
            sr_fill0     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_LOAD;
                        lat_amount   <= cmd_amount;
                        lat_right    <= cmd_right;
                        lat_fill0    <= cmd_right & cmd_fill0;
                        sr_data      <= cmd_data;
                        sr_load      <= 1'b1;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                    end
                end

                S_LOAD: begin
                    sr_load <= 1'b0;
                    if (abort_req) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= lat_amount;
                        if (lat_amount != '0) begin
                            state       <= S_SHIFT;
                            sr_shift_en <= 1'b1;
                            sr_right    <= lat_right;
                            sr_fill0    <= lat_fill0;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                S_SHIFT: begin
                    if (abort_req) begin
                        state       <= S_IDLE;
                        sr_shift_en <= 1'b0;
                        sr_right    <= 1'b0;
                        sr_fill0    <= 1'b0;
                        busy        <= 1'b0;
                    end else begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end
                        // Leaving on cnt==1 gives exactly lat_amount cycles with sr_shift_en high.
                        if (cnt <= CNT_W'(1)) begin
                            state       <= S_DONE;
                            sr_shift_en <= 1'b0;
                            sr_right    <= 1'b0;
                            sr_fill0    <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state        <= S_IDLE;
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    result       <= sr_q;
                    result_valid <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_load_shift_excl: assert property (@(posedge Clock) disable iff (!Reset_b)
        !(sr_load && sr_shift_en));
    a_done_busy: assert property (@(posedge Clock) disable iff (!Reset_b)
        done |-> busy);
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural shift register on sr_*, arithmetic reference model, scoreboard.
// Exercises the abort path too when SHSEQ_ABORT_EN is defined.
module tb_shift_sequencer;

    logic       Clock;
    logic       Reset_b;
    logic       start;
    logic [7:0] cmd_data;
    logic [2:0] cmd_amount;
    logic       cmd_right;
    logic       cmd_fill0;
`ifdef SHSEQ_ABORT_EN
    logic       abort;
`endif
    logic [7:0] sr_q = 8'h00;
    logic       sr_load;
    logic [7:0] sr_data;
    logic       sr_shift_en;
    logic       sr_right;
    logic       sr_fill0;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       result_valid;
    logic [1:0] dbg_state;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_result = 8'h00;

    shift_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
        .Clock        (Clock),
        .Reset_b      (Reset_b),
        .start        (start),
        .cmd_data     (cmd_data),
        .cmd_amount   (cmd_amount),
        .cmd_right    (cmd_right),
        .cmd_fill0    (cmd_fill0),
`ifdef SHSEQ_ABORT_EN
        .abort        (abort),
`endif
        .sr_q         (sr_q),
        .sr_load      (sr_load),
        .sr_data      (sr_data),
        .sr_shift_en  (sr_shift_en),
        .sr_right     (sr_right),
        .sr_fill0     (sr_fill0),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_valid (result_valid),
        .dbg_state    (dbg_state)
    );

    // Clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Behavioural 8-bit rotate/shift register controlled by the DUT
    always_ff @(posedge Clock) begin
        if (sr_load)
            sr_q <= sr_data;
        else if (sr_shift_en) begin
            if (!sr_right)
                sr_q <= {sr_q[6:0], sr_q[7]};
            else if (sr_fill0)
                sr_q <= {1'b0, sr_q[7:1]};
            else
                sr_q <= {sr_q[0], sr_q[7:1]};
        end
    end

    // Reference: whole-word result of the command, by arithmetic
    function automatic logic [7:0] ref_result(input logic [7:0] d, input int n,
                                              input logic r, input logic f);
        int v;
        v = int'(d);
        if (n == 0) return d;
        if (r && f) return 8'(v >> n);
        if (r) return 8'(((v >> n) | (v << (8 - n))) & 255);
        return 8'(((v << n) | (v >> (8 - n))) & 255);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver: call at a negedge with the DUT idle; returns at the negedge of the first IDLE cycle
    task automatic run_cmd(input logic [7:0] d, input int a, input logic r, input logic f,
                           input int inject_at);
        int n_shift, n_load, n_done, load_cyc, done_cyc, ctl_err, busy_err, rv_err;
        logic [7:0] exp_res;
        exp_q.push_back(ref_result(d, a, r, f));
        n_shift = 0; n_load = 0; n_done = 0; load_cyc = -1; done_cyc = -1;
        ctl_err = 0; busy_err = 0; rv_err = 0;
        start = 1'b1; cmd_data = d; cmd_amount = 3'(a); cmd_right = r; cmd_fill0 = f;
        for (int cyc = 1; cyc <= a + 3; cyc++) begin
            @(negedge Clock);
            if (sr_load) begin n_load++; load_cyc = cyc; end
            if (sr_shift_en) n_shift++;
            if (done) begin n_done++; done_cyc = cyc; end
            if (sr_load && sr_shift_en) ctl_err++;
            if (sr_right !== (r & sr_shift_en) || sr_fill0 !== (r & f & sr_shift_en)) ctl_err++;
            if (busy !== (cyc <= a + 2)) busy_err++;
            if (cyc <= a + 2 && result_valid !== 1'b0) rv_err++;
            if (cyc == 1) begin
                start = 1'b0;
                cmd_data = 8'($urandom); cmd_amount = 3'($urandom);
                cmd_right = 1'($urandom); cmd_fill0 = 1'($urandom);
            end
            if (inject_at >= 2 && cyc == inject_at) begin start = 1'b1; cmd_data = 8'hFF; end
            if (inject_at >= 2 && cyc == inject_at + 1) start = 1'b0;
        end
        exp_res = exp_q.pop_front();
        check("load_cycle", load_cyc, 1);
        check("load_count", n_load, 1);
        check("shift_count", n_shift, a);
        check("done_cycle", done_cyc, a + 2);
        check("done_count", n_done, 1);
        check("ctl_select", ctl_err, 0);
        check("busy_window", busy_err, 0);
        check("rv_low_while_busy", rv_err, 0);
        check("result", result, exp_res);
        check("result_valid", result_valid, 1);
        check("sr_data_hold", sr_data, d);
        check("idle_state", dbg_state, 0);
        last_result = exp_res;
    endtask

    initial begin
        Reset_b = 1'b0; start = 1'b0; cmd_data = 8'h00; cmd_amount = 3'd0;
        cmd_right = 1'b0; cmd_fill0 = 1'b0;
`ifdef SHSEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge Clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_sr_load", sr_load, 0);
        check("rst_sr_shift_en", sr_shift_en, 0);
        check("rst_sr_data", sr_data, 0);
        check("rst_state", dbg_state, 0);
        Reset_b = 1'b1;

        // Directed commands (back to back)
        run_cmd(8'h81, 1, 1'b1, 1'b0, 0);
        check("rotr_81_1", result, 8'hC0);
        run_cmd(8'hF0, 3, 1'b1, 1'b1, 0);
        check("lsr_F0_3", result, 8'h1E);
        run_cmd(8'h81, 1, 1'b0, 1'b1, 0);
        check("rotl_81_1", result, 8'h03);
        run_cmd(8'h01, 7, 1'b0, 1'b0, 0);
        check("rotl_01_7", result, 8'h80);
        run_cmd(8'h5A, 0, 1'b1, 1'b0, 0);
        check("zero_amount", result, 8'h5A);
        run_cmd(8'h81, 5, 1'b1, 1'b0, 3);
        check("start_while_busy", result, 8'h0C);

        // Randomized commands, some with ignored starts while busy
        for (int i = 0; i < 25; i++) begin
            int a, inj;
            a = $urandom_range(0, 7);
            inj = 0;
            if ($urandom_range(0, 1) == 1) inj = $urandom_range(2, a + 2);
            run_cmd(8'($urandom), a, 1'($urandom), 1'($urandom), inj);
        end

        // Asynchronous reset in the middle of SHIFT
        start = 1'b1; cmd_data = 8'h81; cmd_amount = 3'd5; cmd_right = 1'b1; cmd_fill0 = 1'b0;
        @(negedge Clock);
        start = 1'b0;
        repeat (2) @(negedge Clock);
        check("pre_reset_busy", busy, 1);
        #2 Reset_b = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        check("arst_result_valid", result_valid, 0);
        check("arst_shift_en", sr_shift_en, 0);
        check("arst_state", dbg_state, 0);
        @(negedge Clock);
        Reset_b = 1'b1;
        last_result = 8'h00;
        run_cmd(8'h3C, 2, 1'b1, 1'b1, 0);
        check("post_reset_cmd", result, 8'h0F);

`ifdef SHSEQ_ABORT_EN
        begin
            int n_done;
            run_cmd(8'h96, 2, 1'b0, 1'b0, 0);
            start = 1'b1; cmd_data = 8'hA5; cmd_amount = 3'd6; cmd_right = 1'b1; cmd_fill0 = 1'b0;
            @(negedge Clock);
            start = 1'b0;
            repeat (2) @(negedge Clock);
            abort = 1'b1;
            @(negedge Clock);
            abort = 1'b0;
            check("abort_state", dbg_state, 0);
            check("abort_busy", busy, 0);
            check("abort_shift_en", sr_shift_en, 0);
            n_done = 0;
            for (int c = 0; c < 4; c++) begin
                if (done) n_done++;
                @(negedge Clock);
            end
            check("abort_no_done", n_done, 0);
            check("abort_rv", result_valid, 0);
            check("abort_result_kept", result, last_result);
            run_cmd(8'h81, 1, 1'b1, 1'b0, 0);
        end
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
